// File: rtl/seven_seg_scan_pkg.sv
// Shared constants and types for the multiplexed seven-segment display driver.
package seven_seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seven_seg_scan_if.sv
// Display bus between the hex-word producer (master) and the scan driver (slave).
interface seven_seg_scan_if;
  logic [31:0] SEVENSEGHEX;
  logic [7:0]  SEVENSEGAN;
  logic [6:0]  SEVENSEGCAT;
  logic        FRAME_START;

  modport master (
    output SEVENSEGHEX,
    input  SEVENSEGAN,
    input  SEVENSEGCAT,
    input  FRAME_START
  );

  modport slave (
    input  SEVENSEGHEX,
    output SEVENSEGAN,
    output SEVENSEGCAT,
    output FRAME_START
  );
endinterface

// File: rtl/seven_seg_scan_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern lookup.
module hex_to_seg7
  import seven_seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/seven_seg_scan.sv
// Eight-digit time-multiplexed seven-segment driver with per-frame snapshot and inter-digit blanking.
// Optional build macro SEVENSEG_LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 65536,
  parameter int BLANK_CYCLES = 256
) (
  input  logic             CLK,
  input  logic             RESET,
  seven_seg_scan_if.slave  bus
);

  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0] BLANK_END = PRE_W'(BLANK_CYCLES);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [2:0]       dig_q, dig_d;
  logic [31:0]      snap_q, snap_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       cat_q, cat_d;
  logic             fs_q;
  logic             pre_wrap, frame_wrap, lz_off;
  logic [6:0]       seg_w;
  scan_state_e      phase;

  hex_to_seg7 u_hex_to_seg7 (
    .nib_i (snap_q[{dig_q, 2'b00} +: 4]),
    .seg_o (seg_w)
  );

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
  // lz_mask[k] is set when nibbles k..7 are all zero; digit 0 never blanks.
  logic [7:0] lz_mask;
  logic       zero_above;

  always_comb begin
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int k = 7; k >= 1; k--) begin
      zero_above = zero_above & (snap_q[4*k +: 4] == 4'h0);
      lz_mask[k] = zero_above;
    end
  end

  assign lz_off = lz_mask[dig_q];
`else
  assign lz_off = 1'b0;
`endif

  always_comb begin
    pre_wrap   = (pre_q == PRE_MAX);
    frame_wrap = pre_wrap && (dig_q == 3'd7);
    pre_d      = pre_wrap ? '0 : pre_q + 1'b1;
    dig_d      = pre_wrap ? dig_q + 3'd1 : dig_q;
    snap_d     = frame_wrap ? bus.SEVENSEGHEX : snap_q;
    phase      = (pre_q < BLANK_END) ? BLANK : DRIVE;
    an_d       = AN_OFF;
    cat_d      = SEG_OFF;
    if ((phase == DRIVE) && !lz_off) begin
      an_d  = ~(8'd1 << dig_q);
      cat_d = seg_w;
    end
  end

  // Outputs are registered from the current scan state, so they trail pre/dig by one cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pre_q  <= '0;
      dig_q  <= '0;
      snap_q <= '0;
      an_q   <= AN_OFF;
      cat_q  <= SEG_OFF;
      fs_q   <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      dig_q  <= dig_d;
      snap_q <= snap_d;
      an_q   <= an_d;
      cat_q  <= cat_d;
      fs_q   <= frame_wrap;
    end
  end

  assign bus.SEVENSEGAN  = an_q;
  assign bus.SEVENSEGCAT = cat_q;
  assign bus.FRAME_START = fs_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with a 4-cycle slot (1 blank + 3 drive), 32-cycle frame.
module tb_seven_seg_scan;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  seven_seg_scan_if bus ();

  seven_seg_scan #(
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (1)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] hex;
    logic [55:0] cats;
    logic [7:0]  mask;
  } vec_t;

  int   total  = 0;
  int   bad    = 0;
  int   n      = 0;
  int   pulses = 0;
  logic lz_en;
  vec_t vecs [5];
  logic [7:0] an_exp [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  function automatic logic [55:0] mk(input logic [6:0] c0, c1, c2, c3, c4, c5, c6, c7);
    return {c7, c6, c5, c4, c3, c2, c1, c0};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%02h want=%02h", name, n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
    n++;
    if (bus.FRAME_START === 1'b1) pulses++;
    chk("frame_start", {7'd0, bus.FRAME_START}, {7'd0, (n % 32 == 0)});
  endtask

  task automatic skip_frame();
    repeat (32) step();
  endtask

  task automatic check_frame(input logic [55:0] cats, input logic [7:0] mask, input string tag);
    for (int d = 0; d < 8; d++) begin
      step();
      chk({tag, "_gap_an"}, bus.SEVENSEGAN, 8'hFF);
      chk({tag, "_gap_cat"}, {1'b0, bus.SEVENSEGCAT}, 8'h7F);
      for (int c = 0; c < 3; c++) begin
        step();
        if (lz_en && mask[d]) begin
          chk({tag, "_lz_an"}, bus.SEVENSEGAN, 8'hFF);
          chk({tag, "_lz_cat"}, {1'b0, bus.SEVENSEGCAT}, 8'h7F);
        end else begin
          chk({tag, "_an"}, bus.SEVENSEGAN, an_exp[d]);
          chk({tag, "_cat"}, {1'b0, bus.SEVENSEGCAT}, {1'b0, cats[7*d +: 7]});
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=timeout want=finish", n);
    $fatal(1);
  end

  initial begin
    logic [55:0] all40;
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
    lz_en = 1'b1;
`else
    lz_en = 1'b0;
`endif
    all40 = mk(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);
    vecs[0] = '{32'h89AB_CDEF, mk(7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00), 8'h00};
    vecs[1] = '{32'h0123_4567, mk(7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40), 8'h80};
    vecs[2] = '{32'h0000_00E0, mk(7'h40, 7'h06, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40), 8'hFC};
    vecs[3] = '{32'h00F0_0000, mk(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h0E, 7'h40, 7'h40), 8'hC0};
    vecs[4] = '{32'h0000_0000, all40, 8'hFE};

    RESET = 1'b0;
    bus.SEVENSEGHEX = 32'h0000_0060;
    repeat (2) begin
      @(negedge CLK);
      chk("rst_an", bus.SEVENSEGAN, 8'hFF);
      chk("rst_cat", {1'b0, bus.SEVENSEGCAT}, 8'h7F);
      chk("rst_fs", {7'd0, bus.FRAME_START}, 8'h00);
    end
    RESET = 1'b1;
    n = 0;

    check_frame(all40, 8'hFE, "first_frame");
    check_frame(mk(7'h40, 7'h02, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40), 8'hFC, "second_frame");

    for (int i = 0; i < 5; i++) begin
      bus.SEVENSEGHEX = vecs[i].hex;
      skip_frame();
      check_frame(vecs[i].cats, vecs[i].mask, "vec");
    end

    // A change right after the snapshot must wait for the following frame.
    bus.SEVENSEGHEX = 32'h0000_0040;
    skip_frame();
    bus.SEVENSEGHEX = 32'h0000_00E0;
    check_frame(mk(7'h40, 7'h19, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40), 8'hFC, "hold");
    check_frame(mk(7'h40, 7'h06, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40), 8'hFC, "update");

    repeat (22) step();
    chk("pre_rst_an", bus.SEVENSEGAN, lz_en ? 8'hFF : 8'hDF);
    #2;
    RESET = 1'b0;
    #1;
    chk("async_rst_an", bus.SEVENSEGAN, 8'hFF);
    chk("async_rst_cat", {1'b0, bus.SEVENSEGCAT}, 8'h7F);
    chk("async_rst_fs", {7'd0, bus.FRAME_START}, 8'h00);
    @(negedge CLK);
    RESET = 1'b1;
    n = 0;
    check_frame(all40, 8'hFE, "after_rst");
    check_frame(mk(7'h40, 7'h06, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40), 8'hFC, "after_rst_e");

    pulses = 0;
    repeat (3) skip_frame();
    chk("fs_count", 8'(pulses), 8'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Time-multiplexed driver for the 8-digit seven-segment display. It sits directly downstream of `Wrapper` and consumes its 32-bit `SEVENSEGHEX` word (8 hex nibbles). It snapshots that word once per refresh frame, scans one digit at a time, inserts a blanking gap between digits to suppress ghosting, and drives the board's active-low anode and cathode pins.

## Interface
- `REFRESH_DIV`, 65536: CLK cycles per digit slot; ≥ `BLANK_CYCLES`+1.
- `BLANK_CYCLES`, 256: cycles at the start of each slot during which all anodes are off; ≥ 1.
- `CLK`  in  1  system clock (same clock as `Wrapper`).
- `RESET`  in  1  asynchronous, active-low reset.
- `SEVENSEGHEX`  in  32  value to display; nibble k drives digit k (digit 0 = rightmost).
- `SEVENSEGAN`  out  8  anode enables, active-low, one-hot-low or all ones.
- `SEVENSEGCAT`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `FRAME_START`  out  1  one-cycle pulse when a new snapshot is taken.

## Operation
- Prescaler `pre` counts 0..`REFRESH_DIV`-1, then wraps to 0. Digit index `dig` (3 bits) increments when `pre` wraps; 7 wraps to 0.
- Snapshot register `snap[31:0]` loads `SEVENSEGHEX` on the cycle `pre` wraps while `dig`==7, so it holds a stable value for all of frame slots 0..7. `FRAME_START` pulses on that same cycle. A mid-frame change of `SEVENSEGHEX` is not visible until the next frame.
- Two-state FSM per slot:
  - BLANK while `pre` < `BLANK_CYCLES`: `SEVENSEGAN` = 8'hFF, `SEVENSEGCAT` = 7'h7F.
  - DRIVE otherwise: `SEVENSEGAN` = ~(1<<`dig`), `SEVENSEGCAT` = seg(`snap[4*dig+3:4*dig]`).
- Segment encoding, active-low:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- Arithmetic: `pre` width is $clog2(`REFRESH_DIV`). No other arithmetic.

## Timing
- Outputs are registered and lag the `pre`/`dig` state by one cycle.
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - `pre`=0, `dig`=0, `snap`=0, `FRAME_START`=0.
  - `SEVENSEGAN`=8'hFF, `SEVENSEGCAT`=7'h7F.
- First snapshot is taken after reset on the first `dig` 7→0 wrap. Until then, frame 0 displays `snap`=0, i.e. all zeros.
- Frame period is 8×`REFRESH_DIV` cycles. Each digit is lit for `REFRESH_DIV`-`BLANK_CYCLES` cycles per frame.
- Reset asserted mid-slot blanks the outputs immediately (asynchronous). The scan restarts at digit 0 with a BLANK phase.
- At most one anode bit is low in any cycle, including across slot boundaries.

## Configuration
- Macro `SEVENSEG_LEADING_ZERO_BLANK_EN`.
- Defined: during DRIVE, digit k keeps its anode off (8'hFF, CAT 7'h7F) if k > 0 and all nibbles k..7 of `snap` are zero. Digit 0 is always shown, so 0 displays as a single "0".
- Undefined: all 8 digits are always driven.

## Structure
- Package `seven_seg_pkg`:
  - `SEG_OFF` = 7'h7F, `AN_OFF` = 8'hFF.
  - 16-entry segment constant table.
  - Typedef for the FSM state {BLANK, DRIVE}.
- Sub-module `hex_to_seg7`: purely combinational nibble → active-low segment lookup, used by the scan logic.

## Test plan
All cases use `REFRESH_DIV`=4, `BLANK_CYCLES`=1.
1. Reset hold, then release with `SEVENSEGHEX`=32'h0000_0060 → during reset AN=FF, CAT=7F. After release, the first frame shows 0x40 ("0") on every digit. The next frame shows digit1 CAT=0x02 ("6") and the other digits 0x40.
2. `SEVENSEGHEX`=32'h89AB_CDEF steady for 2 frames → the second frame's DRIVE phases show, in digit order 0..7, CAT 0E, 06, 21, 46, 03, 08, 10, 00 with AN FE, FD, FB, F7, EF, DF, BF, 7F. Each DRIVE phase is preceded by one cycle of AN=FF.
3. Change `SEVENSEGHEX` from 32'h0000_0040 to 32'h0000_00E0 while `dig`=3 → digit1 stays 0x19 ("4") until the next `FRAME_START`, then becomes 0x06 ("E").
4. Assert `RESET` low while `dig`=5 in DRIVE → AN=FF and CAT=7F in the same cycle. After release, the scan resumes at `dig`=0 BLANK.
5. With `SEVENSEG_LEADING_ZERO_BLANK_EN` and `SEVENSEGHEX`=32'h0000_00E0 → digits 2..7 have AN=FF for the whole slot, digit1 shows 06, digit0 shows 40. Without the macro, digits 2..7 show 40.
6. `FRAME_START` check over 3 frames → exactly one single-cycle pulse every 32 cycles, aligned with the `dig` 7→0 wrap.
